// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter : round-robin IF/LS arbiter onto one AXI-lite memory master
// Revision    : 1.0
// ==========================================================================
module mem_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    IF_REQ,
  input  logic [AXI_AWIDTH-1:0]   IF_ADDR,
  output logic [AXI_DWIDTH-1:0]   IF_RDATA,
  output logic                    IF_ERR,
  output logic                    IF_VALID,
  input  logic                    LS_REQ,
  input  logic                    LS_WE,
  input  logic [AXI_AWIDTH-1:0]   LS_ADDR,
  input  logic [AXI_DWIDTH-1:0]   LS_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] LS_WSTRB,
  output logic [AXI_DWIDTH-1:0]   LS_RDATA,
  output logic                    LS_ERR,
  output logic                    LS_VALID,
  output logic [AXI_AWIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [AXI_DWIDTH-1:0]   M_WDATA,
  output logic [AXI_DWIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [AXI_AWIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  localparam int c_SW = AXI_DWIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_gnt_ls, w_gnt_ls_nxt;
  logic                  r_last_ls, w_last_ls_nxt;
  logic [AXI_AWIDTH-1:0] r_addr, w_addr_nxt;
  logic [AXI_DWIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [c_SW-1:0]       r_wstrb, w_wstrb_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done, w_w_done_nxt;
  logic                  r_b_done, w_b_done_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready, w_rready_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic [AXI_DWIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
  logic                  r_if_err, w_if_err_nxt;
  logic                  r_if_valid, w_if_valid_nxt;
  logic [AXI_DWIDTH-1:0] r_ls_rdata, w_ls_rdata_nxt;
  logic                  r_ls_err, w_ls_err_nxt;
  logic                  r_ls_valid, w_ls_valid_nxt;

  // On a tie the port that did not win last time is chosen.
  logic w_pick_ls;
  assign w_pick_ls = LS_REQ && (!IF_REQ || !r_last_ls);

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_ls_nxt   = r_gnt_ls;
    w_last_ls_nxt  = r_last_ls;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wstrb_nxt    = r_wstrb;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_b_done_nxt   = r_b_done;
    w_arvalid_nxt  = r_arvalid;
    w_rready_nxt   = r_rready;
    w_awvalid_nxt  = r_awvalid;
    w_wvalid_nxt   = r_wvalid;
    w_bready_nxt   = r_bready;
    w_if_rdata_nxt = r_if_rdata;
    w_if_err_nxt   = r_if_err;
    w_if_valid_nxt = 1'b0;
    w_ls_rdata_nxt = r_ls_rdata;
    w_ls_err_nxt   = r_ls_err;
    w_ls_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (IF_REQ || LS_REQ) begin
          w_gnt_ls_nxt  = w_pick_ls;
          w_last_ls_nxt = w_pick_ls;
          w_addr_nxt    = w_pick_ls ? LS_ADDR : IF_ADDR;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_b_done_nxt  = 1'b0;
          if (w_pick_ls) begin
            w_wdata_nxt = LS_WDATA;
            w_wstrb_nxt = LS_WSTRB;
          end
          if (w_pick_ls && LS_WE) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_bready_nxt  = 1'b1;
            w_state_nxt   = S_WR;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_rready_nxt  = 1'b1;
            w_state_nxt   = S_RD;
          end
        end
      end

      S_RD: begin
        if (r_arvalid && M_ARREADY) w_arvalid_nxt = 1'b0;
        if (M_RVALID && r_rready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b0;
          if (r_gnt_ls) begin
            w_ls_rdata_nxt = M_RDATA;
            w_ls_err_nxt   = |M_RRESP;
            w_ls_valid_nxt = 1'b1;
          end else begin
            w_if_rdata_nxt = M_RDATA;
            w_if_err_nxt   = |M_RRESP;
            w_if_valid_nxt = 1'b1;
          end
          w_state_nxt = S_DONE;
        end
      end

      S_WR: begin
        if (r_awvalid && M_AWREADY) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (r_wvalid && M_WREADY) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        // A response arriving before the data handshakes is kept until they finish.
        if (M_BVALID && r_bready) begin
          w_ls_err_nxt = |M_BRESP;
          w_bready_nxt = 1'b0;
          w_b_done_nxt = 1'b1;
        end
        if (w_aw_done_nxt && w_w_done_nxt && w_b_done_nxt) begin
          w_awvalid_nxt  = 1'b0;
          w_wvalid_nxt   = 1'b0;
          w_bready_nxt   = 1'b0;
          w_ls_valid_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state    <= S_IDLE;
      r_gnt_ls   <= 1'b0;
      r_last_ls  <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_b_done   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_if_rdata <= '0;
      r_if_err   <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_rdata <= '0;
      r_ls_err   <= 1'b0;
      r_ls_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_ls   <= w_gnt_ls_nxt;
      r_last_ls  <= w_last_ls_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wstrb    <= w_wstrb_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_b_done   <= w_b_done_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_rready   <= w_rready_nxt;
      r_awvalid  <= w_awvalid_nxt;
      r_wvalid   <= w_wvalid_nxt;
      r_bready   <= w_bready_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_if_err   <= w_if_err_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
      r_ls_err   <= w_ls_err_nxt;
      r_ls_valid <= w_ls_valid_nxt;
    end
  end

  assign IF_RDATA  = r_if_rdata;
  assign IF_ERR    = r_if_err;
  assign IF_VALID  = r_if_valid;
  assign LS_RDATA  = r_ls_rdata;
  assign LS_ERR    = r_ls_err;
  assign LS_VALID  = r_ls_valid;
  assign M_AWADDR  = r_addr;
  assign M_AWVALID = r_awvalid;
  assign M_WDATA   = r_wdata;
  assign M_WSTRB   = r_wstrb;
  assign M_WVALID  = r_wvalid;
  assign M_BREADY  = r_bready;
  assign M_ARADDR  = r_addr;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single AXI-lite data memory between the RV32I core's instruction-fetch port (IF, read-only) and load/store port (LS, read/write).
- Each requester uses a simple req/valid interface. The arbiter owns the AXI-lite master side toward the memory.
- Round-robin grant, one outstanding transaction at a time.

Parameters:
- AXI_AWIDTH, 32, address width on all ports.
- AXI_DWIDTH, 32, data width; strobe width is AXI_DWIDTH/8.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESET  in  1  synchronous reset, active-high
- IF_REQ / IF_ADDR  in  1 / AXI_AWIDTH  fetch request and byte address; held until IF_VALID
- IF_RDATA / IF_ERR / IF_VALID  out  AXI_DWIDTH / 1 / 1  fetch data, error flag (RRESP!=0), one-cycle completion pulse
- LS_REQ / LS_WE / LS_ADDR  in  1 / 1 / AXI_AWIDTH  load/store request, 1=store, byte address; held until LS_VALID
- LS_WDATA / LS_WSTRB  in  AXI_DWIDTH / AXI_DWIDTH/8  store data and byte strobes
- LS_RDATA / LS_ERR / LS_VALID  out  AXI_DWIDTH / 1 / 1  load data, error flag (RRESP or BRESP !=0), completion pulse
- M_AWADDR, M_AWVALID / M_AWREADY  out, out / in  AXI_AWIDTH, 1 / 1  write-address channel
- M_WDATA, M_WSTRB, M_WVALID / M_WREADY  out / in  AXI_DWIDTH, AXI_DWIDTH/8, 1 / 1  write-data channel
- M_BRESP, M_BVALID / M_BREADY  in / out  2, 1 / 1  write-response channel
- M_ARADDR, M_ARVALID / M_ARREADY  out / in  AXI_AWIDTH, 1 / 1  read-address channel
- M_RDATA, M_RRESP, M_RVALID / M_RREADY  in / out  AXI_DWIDTH, 2, 1 / 1  read-data channel

Behaviour:
- Reset (AXI_ARESET=1 at clock edge):
  - State goes to IDLE; last_grant=LS, so IF wins the first tie.
  - All M_*VALID, M_BREADY, M_RREADY, IF_VALID and LS_VALID = 0; IF_ERR and LS_ERR = 0.
  - IF_RDATA = LS_RDATA = 0; M_* address, data and strobe outputs = 0.
  - Reset mid-transaction abandons the transaction immediately: no VALID pulse, no retry.
- FSM states: IDLE, RD, WR, DONE. All outputs are registered.
- IDLE:
  - Only IF_REQ: grant IF.
  - Only LS_REQ: grant LS.
  - Both: grant the port that is not last_grant; update last_grant.
  - Grant latches address, WE, WDATA and WSTRB into internal registers; the requester's later changes are ignored.
  - IF grant, or LS with WE=0 -> RD: M_ARVALID=1, M_RREADY=1, M_ARADDR = latched address.
  - LS with WE=1 -> WR: M_AWVALID=1, M_WVALID=1, M_BREADY=1, address/data/strobe driven from the latched values.
- RD:
  - M_ARVALID held until sampled with M_ARREADY=1, then cleared.
  - M_RREADY held at 1 until the R handshake.
  - On M_RVALID & M_RREADY: capture M_RDATA into the granted port's RDATA, ERR = (M_RRESP!=0), pulse that port's VALID, clear M_ARVALID and M_RREADY, go to DONE.
  - AR and R handshakes in the same cycle are legal and complete the read.
- WR:
  - M_AWVALID and M_WVALID are dropped independently on their own handshakes; aw_done and w_done flags track each.
  - On M_BVALID & M_BREADY: LS_ERR = (M_BRESP!=0).
  - Complete once aw_done, w_done and the B handshake have all occurred, including all in the same cycle. Then pulse LS_VALID, clear all M_* valids and M_BREADY, go to DONE.
  - An early M_BVALID before both data handshakes is still recorded.
- DONE:
  - VALID is high exactly this one cycle; go to IDLE.
  - No grant occurs in DONE, so a requester may deassert REQ on the edge after VALID without causing a spurious re-grant.
- Latency with the single-cycle-ready memory: REQ seen at edge 1 -> handshake at edge 3 -> VALID high between edges 3 and 4. Back-to-back grant is earliest at edge 5.
- Only the granted port's RDATA/ERR update; the other port's outputs hold.
- RDATA is not updated on stores.

Test Plan:
- Memory word 0x40 preloaded with 0x12345678. IF_REQ=1, IF_ADDR=0x100 -> M_ARADDR=0x100, IF_VALID pulses 1 cycle with IF_RDATA=0x12345678 and IF_ERR=0, 3 cycles after the request edge.
- LS store, ADDR=0x20, WDATA=0xAABBCCDD, WSTRB=4'b0101, memory pre-zeroed -> LS_VALID pulse, LS_ERR=0. A subsequent LS load of 0x20 returns 0x00BB00DD.
- IF_REQ and LS_REQ both held continuously after reset -> grants alternate IF, LS, IF, LS; no more than one M_ARVALID/M_AWVALID active at any time.
- Slave model delays M_WREADY 3 cycles after M_AWREADY and returns M_BRESP=2'b10 -> M_AWVALID drops after its handshake, M_WVALID stays high until WREADY, LS_ERR=1 with LS_VALID.
- AXI_ARESET asserted in the cycle after an RD grant -> all outputs 0 next edge, no IF_VALID pulse. A fresh request after release completes normally.
- REQ deasserted the cycle after VALID -> no second transaction issued; M_ARVALID stays 0.
